// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-master RAM arbiter.
// Reset level and write/read encodings match the core defines so the
// arbiter drops straight into the core's RAM path.
package ram_arbiter_pkg;

   localparam logic RstEnable   = 1'b0;  // active-low reset level
   localparam logic WriteEnable = 1'b1;
   localparam logic ReadEnable  = 1'b0;

   typedef enum logic {
      MST_M0 = 1'b0,
      MST_M1 = 1'b1
   } mst_e;

   // Index of the granted master from a one-hot (or zero) grant vector.
   function automatic mst_e winner_of(input logic [1:0] gnt);
      return gnt[1] ? MST_M1 : MST_M0;
   endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin grant unit. The grant is combinational in the
// request cycle; the priority pointer moves to the loser after every
// grant so a continuously requesting pair alternates.
module rr_arb2
   import ram_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic rr_ptr_q, rr_ptr_d;

   // Pick the winner: a lone requester always wins, a tie goes to rr_ptr.
   always_comb begin
      gnt_o    = 2'b00;
      rr_ptr_d = rr_ptr_q;
      if (rst != RstEnable) begin
         unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = rr_ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
      if (|gnt_o) rr_ptr_d = ~gnt_o[1];
   end

   // Pointer register; m0 has priority out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) rr_ptr_q <= 1'b0;
      else                  rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/ram_arbiter.sv
// Time-shares one single-port synchronous-read RAM between the core
// load/store port (m0) and a secondary master (m1). One access per cycle,
// round-robin on contention, read data returned to its owner one cycle
// after the grant.
// Optional: define RAM_ARB_RDATA_HOLD_EN to keep each master's last read
// data on its rdata output until that master's next read response.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req_i,
   input  logic          m0_we_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_data_i,
   input  logic [MW-1:0] m0_sel_i,
   output logic          m0_gnt_o,
   output logic          m0_rvalid_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_req_i,
   input  logic          m1_we_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_data_i,
   input  logic [MW-1:0] m1_sel_i,
   output logic          m1_gnt_o,
   output logic          m1_rvalid_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [DW-1:0] ram_data_o,
   output logic [MW-1:0] ram_sel_o,
   output logic          ram_we_o,
   input  logic [DW-1:0] ram_data_i
);

   logic [1:0]          req, gnt, rvalid;
   logic [1:0]          we_a;
   logic [1:0][AW-1:0]  addr_a;
   logic [1:0][DW-1:0]  data_a;
   logic [1:0][MW-1:0]  sel_a;
   logic [1:0][DW-1:0]  idle_rdata;
   logic                win;

   logic rsp_pend_q, rsp_pend_d;
   mst_e rsp_owner_q, rsp_owner_d;

   assign req    = {m1_req_i,  m0_req_i};
   assign we_a   = {m1_we_i,   m0_we_i};
   assign addr_a = {m1_addr_i, m0_addr_i};
   assign data_a = {m1_data_i, m0_data_i};
   assign sel_a  = {m1_sel_i,  m0_sel_i};

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .rst   (rst),
      .req_i (req),
      .gnt_o (gnt)
   );

   assign m0_gnt_o = gnt[0];
   assign m1_gnt_o = gnt[1];
   assign win      = gnt[1];

   // Forward the winner's payload; park the RAM bus at zero when idle.
   always_comb begin
      ram_addr_o = '0;
      ram_data_o = '0;
      ram_sel_o  = '0;
      ram_we_o   = ReadEnable;
      if (|gnt) begin
         ram_addr_o = addr_a[win];
         ram_data_o = data_a[win];
         ram_sel_o  = sel_a[win];
         ram_we_o   = we_a[win];
      end
   end

   // A granted read owes its master a response next cycle; writes owe none.
   always_comb begin
      rsp_pend_d  = (|gnt) && (we_a[win] == ReadEnable);
      rsp_owner_d = (|gnt) ? winner_of(gnt) : rsp_owner_q;
   end

   // Response tracking; a reset drops any outstanding response.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         rsp_pend_q  <= 1'b0;
         rsp_owner_q <= MST_M0;
      end else begin
         rsp_pend_q  <= rsp_pend_d;
         rsp_owner_q <= rsp_owner_d;
      end
   end

   assign rvalid[0] = rsp_pend_q && (rsp_owner_q == MST_M0);
   assign rvalid[1] = rsp_pend_q && (rsp_owner_q == MST_M1);

`ifdef RAM_ARB_RDATA_HOLD_EN
   logic [1:0][DW-1:0] hold_q, hold_d;

   // Capture each master's read data in its rvalid cycle.
   always_comb begin
      hold_d = hold_q;
      for (int i = 0; i < 2; i++)
         if (rvalid[i]) hold_d[i] = ram_data_i;
   end

   // Per-master hold registers.
   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) hold_q <= '0;
      else                  hold_q <= hold_d;
   end

   assign idle_rdata = hold_q;
`else
   assign idle_rdata = '0;
`endif

   assign m0_rvalid_o = rvalid[0];
   assign m1_rvalid_o = rvalid[1];
   assign m0_rdata_o  = rvalid[0] ? ram_data_i : idle_rdata[0];
   assign m1_rdata_o  = rvalid[1] ? ram_data_i : idle_rdata[1];

endmodule
